// File: rtl/spike_event_logger.sv
// spike_event_logger
//   Timestamps spike events from the adaptive-threshold neuron and buffers
//   them in a first-word-fall-through FIFO. A readout host drains the FIFO
//   over a valid/ready handshake. Lost events are flagged and counted.
//
// Optional feature macro: TS_ROLLOVER_EN
//   When defined, a marker entry is pushed on every timestamp wrap, so the
//   host can extend the timestamp in software.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   spike_in          one event per high cycle (while enable=1)
//   state_in[7:0]     membrane state captured with the spike
//   enable            timestamp advance / capture enable
//   clear             synchronous flush of FIFO, timestamp, flags
//   ev_valid/ready    FIFO head handshake
//   ev_data           {marker, spike, ts[TS_WIDTH-1:0], state[7:0]}, 0 when empty
//   level             FIFO occupancy 0..DEPTH
//   overflow          sticky drop flag
//   drop_count        saturating count of dropped events
module spike_event_logger #(
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spike_in,
  input  logic [7:0]              state_in,
  input  logic                    enable,
  input  logic                    clear,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [TS_WIDTH+9:0]     ev_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              drop_count
);
  localparam int DW        = TS_WIDTH + 10;
  localparam int AW        = $clog2(DEPTH);
  localparam int CNT_WIDTH = AW + 1;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [DW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CNT_WIDTH-1:0] r_level;
  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_ovf;
  logic [7:0]           r_drop;

  logic          w_marker, w_push_req, w_push, w_pop, w_drop, w_full, w_empty;
  logic [7:0]    w_state;
  logic [DW-1:0] w_entry;

`ifdef TS_ROLLOVER_EN
  // ts is all-ones exactly on the wrap edge, so the entry's ts field is
  // all-ones without special casing.
  assign w_marker = enable & (r_ts == {TS_WIDTH{1'b1}});
`else
  assign w_marker = 1'b0;
`endif

  assign w_push_req = enable & (spike_in | w_marker);
  // A marker-only entry carries state 0.
  assign w_state    = spike_in ? state_in : 8'h00;
  assign w_entry    = {w_marker, spike_in, r_ts, w_state};

  assign w_full  = (r_level == FULL);
  assign w_empty = (r_level == '0);
  assign w_pop   = ~w_empty & ev_ready;
  // When full, a same-edge pop frees the slot the push lands in.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ts    <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (enable) r_ts <= r_ts + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_push) r_mem[r_wptr] <= w_entry;
  end

  assign ev_valid   = ~w_empty;
  assign ev_data    = w_empty ? '0 : r_mem[r_rptr];
  assign level      = r_level;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
endmodule
